// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: round-robin share of one 8-bit XOR unit among four requesters; ARB_FIXED_PRIORITY_EN selects fixed priority
module xor_unit_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic [1:0]  muxSel,
  output logic        xorEn,
  output logic [7:0]  dOut,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] reg_a, reg_b;
  logic [3:0] cnt;
  logic [1:0] win, base;
  logic hold;
  assign hold = req[muxSel];
`ifdef ARB_FIXED_PRIORITY_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr;
  assign base = ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= 2'd0;
    else if (state == DONE || ((state == LOAD || state == EXEC) && !hold)) ptr <= muxSel + 2'd1;
`endif
  always_comb begin
    win = base;
    for (int i = 3; i >= 0; i--)
      if (req[base + 2'(i)]) win = base + 2'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = |req ? LOAD : IDLE;
      LOAD: state_n = hold ? EXEC : IDLE;
      EXEC: state_n = !hold ? IDLE : (cnt == LAST) ? DONE : EXEC;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      grant  <= 4'd0;
      muxSel <= 2'd0;
      reg_a  <= 8'd0;
      reg_b  <= 8'd0;
      cnt    <= 4'd0;
      dOut   <= 8'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        grant  <= 4'b0001 << win;
        muxSel <= win;
      end else if (state_n == IDLE) grant <= 4'd0;
      if (state == LOAD) begin
        reg_a <= opA[{muxSel, 3'b000} +: 8];
        reg_b <= opB[{muxSel, 3'b000} +: 8];
        cnt   <= 4'd0;
      end
      if (state == EXEC) cnt <= cnt + 4'd1;
      if (state == EXEC && state_n == DONE) dOut <= reg_a ^ reg_b;
    end
  assign xorEn = state == EXEC;
  assign busy  = state != IDLE;
  assign ack   = state == DONE ? grant : 4'd0;
endmodule

// File: tb/tb_xor_unit_arbiter.sv
// tb_xor_unit_arbiter: directed and randomized checks of xor_unit_arbiter against a transaction-level model
module tb_xor_unit_arbiter;
  logic clk = 0;
  logic rst, rst2;
  logic [3:0] req, req2;
  logic [31:0] opA, opB, opA2, opB2;
  logic [3:0] grant, ack, grant2, ack2;
  logic [1:0] muxSel, muxSel2;
  logic xorEn, busy, xorEn2, busy2;
  logic [7:0] dOut, dOut2;
  int passed = 0, total = 0;
  int ptr = 0;
  logic [7:0] last = 8'd0;

  xor_unit_arbiter #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .opA(opA), .opB(opB), .grant(grant), .ack(ack),
    .muxSel(muxSel), .xorEn(xorEn), .dOut(dOut), .busy(busy));
  xor_unit_arbiter #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst2), .req(req2), .opA(opA2), .opB(opB2), .grant(grant2), .ack(ack2),
    .muxSel(muxSel2), .xorEn(xorEn2), .dOut(dOut2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  function automatic void advance(input int w);
`ifndef ARB_FIXED_PRIORITY_EN
    ptr = (w + 1) % 4;
`endif
  endfunction

  task automatic reset_main();
    rst = 1;
    req = 0;
    step();
    step();
    rst = 0;
    ptr = 0;
    last = 8'd0;
  endtask

  // abort_at: 0 = complete, 1 = drop req in LOAD, 2 = drop req in EXEC
  task automatic run_txn(input logic [3:0] mask, input int abort_at, input bit rnd, input bit keep);
    int w;
    logic [7:0] a, b;
    if (rnd) begin
      opA = $urandom;
      opB = $urandom;
    end
    req = mask;
    w = pick(mask);
    a = opA[8*w +: 8];
    b = opB[8*w +: 8];
    step();
    chk("grant", grant, 32'(1 << w));
    chk("muxSel", muxSel, w);
    chk("busy_load", busy, 1);
    if (abort_at == 1) begin
      req = 0;
      step();
      chk("abort_load_busy", busy, 0);
      chk("abort_load_ack", ack, 0);
      chk("abort_load_dout", dOut, last);
      advance(w);
      return;
    end
    step();
    chk("xorEn", xorEn, 1);
    chk("ack_exec", ack, 0);
    if (rnd) begin
      opA = $urandom;
      opB = $urandom;
    end
    if (abort_at == 2) begin
      req = 0;
      step();
      chk("abort_exec_busy", busy, 0);
      chk("abort_exec_ack", ack, 0);
      chk("abort_exec_xorEn", xorEn, 0);
      chk("abort_exec_dout", dOut, last);
      advance(w);
      return;
    end
    step();
    chk("ack", ack, 32'(1 << w));
    chk("dOut", dOut, a ^ b);
    chk("xorEn_done", xorEn, 0);
    last = a ^ b;
    advance(w);
    req = keep ? mask : 4'd0;
    step();
    chk("busy_idle", busy, 0);
    chk("grant_idle", grant, 0);
    chk("ack_idle", ack, 0);
  endtask

  initial begin
    int c, xcnt, ack_cyc;
    rst = 1; rst2 = 1; req = 0; req2 = 0;
    opA = 0; opB = 0; opA2 = 0; opB2 = 0;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_muxSel", muxSel, 0);
    chk("rst_xorEn", xorEn, 0);
    chk("rst_dOut", dOut, 0);
    chk("rst_busy", busy, 0);
    rst = 0; rst2 = 0;

    opA = 32'h0000_00A5; opB = 32'h0000_000F;
    run_txn(4'b0001, 0, 0, 0);
    chk("single_dout", dOut, 8'hAA);

    reset_main();
    opA = 32'h3020_1000; opB = 32'hFFFF_FFFF;
    run_txn(4'b1111, 0, 0, 0);
    run_txn(4'b1110, 0, 0, 0);
    run_txn(4'b1100, 0, 0, 0);
    run_txn(4'b1000, 0, 0, 0);
    chk("all4_last_dout", dOut, 8'hCF);

    reset_main();
    for (int i = 0; i < 6; i++) run_txn(4'b0101, 0, 1, 1);

    reset_main();
    opA = 32'h0000_003C; opB = 32'h0;
    run_txn(4'b0001, 0, 0, 0);
    run_txn(4'b0010, 2, 1, 0);
    chk("abort_hold_3c", dOut, 8'h3C);
    run_txn(4'b0110, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 5);
      run_txn(4'($urandom_range(1, 15)), r < 2 ? r + 1 : 0, 1, $urandom_range(0, 1));
    end

    opA2 = 32'h005A_0000; opB2 = 32'h0003_0000;
    req2 = 4'b0100;
    c = 0; xcnt = 0; ack_cyc = -1;
    while (ack_cyc < 0 && c < 10) begin
      step();
      c++;
      if (xorEn2) xcnt++;
      if (ack2 != 0) ack_cyc = c;
    end
    chk("long_xorEn_cycles", xcnt, 3);
    chk("long_ack_cycle", ack_cyc, 5);
    chk("long_ack", ack2, 4'b0100);
    chk("long_dout", dOut2, 8'h59);
    req2 = 0;
    step();
    chk("long_busy_idle", busy2, 0);

    req2 = 4'b0010;
    step();
    chk("mid_grant", grant2, 4'b0010);
    step();
    chk("mid_exec1", xorEn2, 1);
    step();
    chk("mid_exec2", xorEn2, 1);
    rst2 = 1;
    step();
    rst2 = 0;
    chk("mid_rst_grant", grant2, 0);
    chk("mid_rst_xorEn", xorEn2, 0);
    chk("mid_rst_busy", busy2, 0);
    chk("mid_rst_dout", dOut2, 0);
    chk("mid_rst_ack", ack2, 0);
    req2 = 4'b1010;
    step();
    chk("mid_ptr_reset_grant", grant2, 4'b0010);
    chk("mid_ptr_reset_muxSel", muxSel2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
